// File: rtl/sha_nonce_sequencer_if.sv
// Bundle between the nonce sequencer and its work-input / transform neighbours.
// Optional TARGET_CHECK_EN adds the hash comparator signals.
interface sha_nonce_sequencer_if;
    logic         start;
    logic         stop;
    logic [255:0] midstate;
    logic [511:0] data_tail;
    logic [31:0]  nonce_start;
    logic [31:0]  nonce_end;
    logic [5:0]   cnt;
    logic         feedback;
    logic [255:0] rx_state;
    logic [511:0] rx_input;
    logic         busy;
    logic         done;
    logic         hash_valid;
    logic [31:0]  hash_nonce;
`ifdef TARGET_CHECK_EN
    logic [255:0] hash_in;
    logic [31:0]  target_h7;
    logic         golden;
    logic [31:0]  golden_nonce;

    modport master (
        output start, stop, midstate, data_tail, nonce_start, nonce_end,
        output hash_in, target_h7,
        input  cnt, feedback, rx_state, rx_input, busy, done, hash_valid, hash_nonce,
        input  golden, golden_nonce
    );
    modport slave (
        input  start, stop, midstate, data_tail, nonce_start, nonce_end,
        input  hash_in, target_h7,
        output cnt, feedback, rx_state, rx_input, busy, done, hash_valid, hash_nonce,
        output golden, golden_nonce
    );
`else
    modport master (
        output start, stop, midstate, data_tail, nonce_start, nonce_end,
        input  cnt, feedback, rx_state, rx_input, busy, done, hash_valid, hash_nonce
    );
    modport slave (
        input  start, stop, midstate, data_tail, nonce_start, nonce_end,
        output cnt, feedback, rx_state, rx_input, busy, done, hash_valid, hash_nonce
    );
`endif
endinterface

// File: rtl/sha_nonce_sequencer.sv
// Nonce sequencer for an unrolled sha256_transform: drives the round phase, issues jobs
// and tags returning hashes with their nonce. Optional macro TARGET_CHECK_EN adds a golden-hash comparator.
module sha_nonce_sequencer #(
    parameter int LOOP      = 4,
    parameter int LATENCY   = 65,
    parameter int TAG_DEPTH = 64 / LOOP + 2
) (
    input logic                  clk,
    input logic                  rst_n,
    sha_nonce_sequencer_if.slave bus
);
    localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CNT_W = $clog2(TAG_DEPTH + 1);
    localparam logic [511:0] NONCE_MASK = 512'hFFFF_FFFF << 96;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [5:0]         cnt_q;
    logic               slot;
    logic [31:0]        nonce_q;
    logic [31:0]        nonce_end_q;
    logic [255:0]       midstate_q;
    logic [511:0]       tail_q;
    logic               accept;
    logic               issue;
    logic               finish;
    logic               busy;
    logic               drained;
    logic [LATENCY-1:0] vld_line;
    logic               vld_p1;
    logic               done_q;
    logic [31:0]        tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   tag_cnt;
    logic               tag_push;
    logic               tag_pop;
    logic [31:0]        hash_nonce_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(TAG_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Round phase free-runs regardless of the scan state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (cnt_q == 6'(LOOP - 1)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 6'd1;
        end
    end

    assign slot    = (cnt_q == '0);
    assign drained = (vld_line == '0) && (tag_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN: begin
                if (bus.stop) begin
                    state_next = DRAIN;
                end else if (slot && (nonce_q == nonce_end_q)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN:   if (drained) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // stop wins over a coinciding issue slot.
    always_comb begin
        accept = 1'b0;
        issue  = 1'b0;
        finish = 1'b0;
        busy   = 1'b0;
        unique case (state)
            IDLE:  accept = bus.start;
            RUN: begin
                busy  = 1'b1;
                issue = slot && !bus.stop;
            end
            DRAIN: begin
                busy   = 1'b1;
                finish = drained;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nonce_q     <= '0;
            nonce_end_q <= '0;
            midstate_q  <= '0;
            tail_q      <= '0;
        end else if (accept) begin
            nonce_q     <= bus.nonce_start;
            nonce_end_q <= bus.nonce_end;
            midstate_q  <= bus.midstate;
            tail_q      <= bus.data_tail;
        end else if (issue && (nonce_q != nonce_end_q)) begin
            nonce_q <= nonce_q + 32'd1;
        end
    end

    // Valid line mirrors the transform pipeline; vld_p1 lines up with tx_hash.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_line <= '0;
            vld_p1   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            vld_line <= {vld_line[LATENCY-2:0], issue};
            vld_p1   <= vld_line[LATENCY-1];
            done_q   <= finish;
        end
    end

    assign tag_push = issue;
    assign tag_pop  = vld_line[LATENCY-1];

    always_ff @(posedge clk) begin
        if (tag_push) begin
            tag_mem[wr_ptr] <= nonce_q;
        end
    end

    // The tag is popped on the edge that raises hash_valid, so hash_nonce is valid alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            tag_cnt      <= '0;
            hash_nonce_q <= '0;
        end else begin
            if (tag_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (tag_pop) begin
                rd_ptr       <= ptr_inc(rd_ptr);
                hash_nonce_q <= tag_mem[rd_ptr];
            end
            unique case ({tag_push, tag_pop})
                2'b10:   tag_cnt <= tag_cnt + CNT_W'(1);
                2'b01:   tag_cnt <= tag_cnt - CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign bus.cnt        = cnt_q;
    assign bus.feedback   = (cnt_q != '0);
    assign bus.rx_state   = midstate_q;
    assign bus.rx_input   = (tail_q & ~NONCE_MASK) | ({480'd0, nonce_q} << 96);
    assign bus.busy       = busy;
    assign bus.done       = done_q;
    assign bus.hash_valid = vld_p1;
    assign bus.hash_nonce = hash_nonce_q;

`ifdef TARGET_CHECK_EN
    logic        golden;
    logic [31:0] golden_nonce_q;

    assign golden = vld_p1 && (bus.hash_in[255:224] < bus.target_h7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            golden_nonce_q <= '0;
        end else if (golden) begin
            golden_nonce_q <= hash_nonce_q;
        end
    end

    assign bus.golden       = golden;
    assign bus.golden_nonce = golden_nonce_q;
`endif

endmodule

// File: tb/tb_sha_nonce_sequencer.sv
// Directed bench for sha_nonce_sequencer with a cycle-level scoreboard of expected tagged hashes.
module tb_sha_nonce_sequencer;
    localparam int LOOP      = 4;
    localparam int LATENCY   = 65;
    localparam int TAG_DEPTH = 64 / LOOP + 2;
    localparam int S_IDLE = 0, S_RUN = 1, S_DRAIN = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    sha_nonce_sequencer_if bus();

    sha_nonce_sequencer #(
        .LOOP(LOOP), .LATENCY(LATENCY), .TAG_DEPTH(TAG_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    typedef struct {
        logic [31:0] nonce;
        int          cyc;
    } exp_t;

    exp_t         expq[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           hv_count = 0;
    int           m_state = S_IDLE;
    logic [5:0]   m_cnt = '0;
    logic [31:0]  m_nonce = '0;
    logic [31:0]  m_end = '0;
    logic [31:0]  m_hn = '0;
    logic         m_done = 1'b0;
    logic [255:0] m_mid = '0;
    logic [511:0] m_tail = '0;

`ifdef TARGET_CHECK_EN
    logic [31:0] m_gn = '0;
    int          gold_count = 0;
    // Only the pulse tagged 0x42 carries a hash below the 0x100 target.
    assign bus.hash_in = {(bus.hash_nonce == 32'h42) ? 32'h0000_00FF : 32'h0000_0100, 224'd0};
`endif

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic exp_hv;
        logic [511:0] exp_rx;
        cyc++;
        if (!rst_n) begin
            chk("rst_cnt", bus.cnt, 0);
            chk("rst_feedback", bus.feedback, 0);
            chk("rst_busy", bus.busy, 0);
            chk("rst_done", bus.done, 0);
            chk("rst_hash_valid", bus.hash_valid, 0);
            chk("rst_hash_nonce", bus.hash_nonce, 0);
            chk("rst_rx_state", bus.rx_state, 0);
            chk("rst_rx_input", bus.rx_input, 0);
`ifdef TARGET_CHECK_EN
            chk("rst_golden", bus.golden, 0);
            chk("rst_golden_nonce", bus.golden_nonce, 0);
            m_gn = '0;
`endif
            m_state = S_IDLE;
            m_cnt   = '0;
            m_nonce = '0;
            m_end   = '0;
            m_hn    = '0;
            m_done  = 1'b0;
            m_mid   = '0;
            m_tail  = '0;
            expq.delete();
        end else begin
            chk("cnt", bus.cnt, m_cnt);
            chk("feedback", bus.feedback, m_cnt != 0);
            chk("busy", bus.busy, m_state != S_IDLE);
            chk("done", bus.done, m_done);
            chk("rx_state", bus.rx_state, m_mid);
            exp_hv = (expq.size() > 0) && (expq[0].cyc == cyc);
            chk("hash_valid", bus.hash_valid, exp_hv);
`ifdef TARGET_CHECK_EN
            chk("golden_nonce", bus.golden_nonce, m_gn);
`endif
            if (exp_hv) begin
                e = expq.pop_front();
                m_hn = e.nonce;
                hv_count++;
            end
            chk("hash_nonce", bus.hash_nonce, m_hn);
`ifdef TARGET_CHECK_EN
            chk("golden", bus.golden, exp_hv && (e.nonce == 32'h42));
            if (exp_hv && (e.nonce == 32'h42)) begin
                m_gn = e.nonce;
                gold_count++;
            end
`endif
            if (dut.tag_push) chk("tag_push_when_full", dut.tag_cnt == TAG_DEPTH, 0);
            if (dut.tag_pop) chk("tag_pop_when_empty", dut.tag_cnt == 0, 0);

            m_done = 1'b0;
            case (m_state)
                S_IDLE: begin
                    if (bus.start) begin
                        m_mid   = bus.midstate;
                        m_tail  = bus.data_tail;
                        m_nonce = bus.nonce_start;
                        m_end   = bus.nonce_end;
                        m_state = S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.stop) begin
                        m_state = S_DRAIN;
                    end else if (m_cnt == 0) begin
                        exp_rx = {m_tail[511:128], m_nonce, m_tail[95:0]};
                        chk("rx_input", bus.rx_input, exp_rx);
                        expq.push_back('{nonce: m_nonce, cyc: cyc + LATENCY + 1});
                        if (m_nonce == m_end) m_state = S_DRAIN;
                        else m_nonce = m_nonce + 32'd1;
                    end
                end
                default: begin
                    if (expq.size() == 0) begin
                        m_state = S_IDLE;
                        m_done  = 1'b1;
                    end
                end
            endcase
            m_cnt = (m_cnt == LOOP - 1) ? 6'd0 : m_cnt + 6'd1;
        end
    end

    task automatic load_job(input logic [31:0] ns, input logic [31:0] ne);
        bus.midstate = {$urandom(), $urandom(), $urandom(), $urandom(),
                        $urandom(), $urandom(), $urandom(), $urandom()};
        for (int k = 0; k < 16; k++) bus.data_tail[k*32 +: 32] = $urandom();
        bus.nonce_start = ns;
        bus.nonce_end   = ne;
    endtask

    task automatic wait_done(input string tag);
        logic got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            got = bus.done;
        end
        chk({tag, "_done_seen"}, got, 1);
    endtask

    task automatic run_scan(input string tag, input logic [31:0] ns, input logic [31:0] ne,
                            input logic with_stop, input int exp_jobs);
        int base;
        base = hv_count;
        @(posedge clk); #1;
        load_job(ns, ne);
        bus.start = 1'b1;
        bus.stop  = with_stop;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        wait_done(tag);
        chk({tag, "_jobs"}, hv_count - base, exp_jobs);
    endtask

    task automatic wait_slots(input int n);
        int slots = 0;
        for (int i = 0; i < 1000 && slots < n; i++) begin
            @(posedge clk); #1;
            if (bus.cnt == 0 && bus.busy) slots++;
        end
        chk("slot_wait", slots, n);
    endtask

    initial begin
        int base;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        load_job(32'd0, 32'd0);
`ifdef TARGET_CHECK_EN
        bus.target_h7 = 32'h0000_0100;
`endif
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle after reset: phase runs, nothing issues.
        repeat (10) @(posedge clk);
        chk("idle_no_hash", hv_count, 0);

        // Basic scan; stop raised with start in IDLE must be ignored.
        run_scan("scan_10_13", 32'h10, 32'h13, 1'b1, 4);
        run_scan("scan_wrap", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 4);
        run_scan("scan_single", 32'h77, 32'h77, 1'b0, 1);

        // Stop on the third issue slot, then a start during DRAIN.
        base = hv_count;
        @(posedge clk); #1;
        load_job(32'h0, 32'hFF);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_slots(2);
        wait_slots(1);
        bus.stop = 1'b1;
        @(posedge clk); #1;
        bus.stop = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        load_job(32'h500, 32'h5FF);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done("stop_scan");
        chk("stop_scan_jobs", hv_count - base, 2);
        repeat (120) @(posedge clk);
        chk("stop_scan_no_extra", hv_count - base, 2);

        // Reset with five jobs in flight.
        @(posedge clk); #1;
        load_job(32'h0, 32'hFF);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_slots(5);
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        base = hv_count;
        repeat (100) @(posedge clk);
        chk("reset_no_hash", hv_count - base, 0);
        @(negedge clk);
        chk("reset_rx_input", bus.rx_input, 0);
        chk("reset_rx_state", bus.rx_state, 0);
        chk("reset_busy", bus.busy, 0);

`ifdef TARGET_CHECK_EN
        run_scan("golden_scan", 32'h40, 32'h44, 1'b0, 5);
        chk("golden_pulses", gold_count, 1);
        chk("golden_nonce_final", bus.golden_nonce, 32'h42);
`endif

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/sha_nonce_sequencer.md
Name: sha_nonce_sequencer

Overview:
Upstream control stage for sha256_transform. Drives its cnt/feedback phase and injects one 512-bit job per LOOP cycles: a latched data tail with an incrementing nonce spliced in, plus a latched midstate. Tracks in-flight nonces so each hash leaving the transform is tagged with the nonce that produced it. Sits between the work-input register block and the transform/result checker.

Parameters:
LOOP, 4, unroll factor of the attached transform; must divide 64; cnt wraps at LOOP-1
LATENCY, 65, cycles from a job-issue clock edge to the clock edge where tx_hash for that job is valid (64 rounds + output register)
TAG_DEPTH, 64/LOOP+2, depth of the in-flight nonce tag queue

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin scan; sampled only in IDLE
stop  in  1  abort issuing; sampled only in RUN
midstate  in  256  first-block state; latched on accepted start
data_tail  in  512  second-block words; latched on accepted start
nonce_start  in  32  first nonce issued
nonce_end  in  32  last nonce issued (inclusive)
cnt  out  6  round phase to transform, 0..LOOP-1
feedback  out  1  to transform; 0 only when cnt==0
rx_state  out  256  latched midstate
rx_input  out  512  latched data_tail with bits [127:96] replaced by current nonce
busy  out  1  high in RUN and DRAIN
done  out  1  one-cycle pulse on scan completion
hash_valid  out  1  one-cycle pulse: transform tx_hash valid this cycle
hash_nonce  out  32  nonce of the hash flagged by hash_valid; holds otherwise

Behaviour:
- Reset (async, rst_n low): state IDLE; cnt=0; nonce reg=0; midstate/data latches=0; tag queue empty; in-flight shift register cleared; busy=0, done=0, hash_valid=0, hash_nonce=0. feedback=0 follows from cnt=0.
- cnt free-runs every cycle out of reset, 0..LOOP-1, then wraps. feedback = (cnt != 0), combinational from registered cnt. The phase is independent of the state.
- Issue slot = cycle with cnt==0. A job is issued only in RUN on an issue slot. Non-RUN slots still load rx_input into the transform as bubbles with no tag.
- States:
  - IDLE: on start, latch midstate, data_tail, nonce_start, nonce_end; go to RUN.
  - RUN: on each issue slot, push current nonce into the tag queue and a 1 into the LATENCY-long valid shift register. If nonce == nonce_end, go to DRAIN; otherwise nonce <= nonce+1 (mod 2^32). stop goes to DRAIN without issuing that cycle, even if it coincides with an issue slot.
  - DRAIN: no issues. When the valid shift register is all zero and the tag queue is empty, pulse done and go to IDLE.
- Non-issue cycles shift a 0 into the valid shift register.
- Wrap-around: nonce_end < nonce_start is legal. The nonce counts through 0xFFFFFFFF to 0. nonce_start == nonce_end issues exactly one job.
- hash_valid = tail bit of the valid shift register, registered so it aligns with tx_hash. On hash_valid: pop the tag queue; hash_nonce <= popped value.
- Tag queue must never overflow for TAG_DEPTH >= 64/LOOP+1. Bench asserts no push-when-full and no pop-when-empty.
- start while not IDLE: ignored. stop while not RUN: ignored. Simultaneous start and stop in IDLE: start wins; stop is ignored.
- Reset mid-scan: all in-flight tags are discarded and no hash_valid is produced for them.

Optional Feature:
TARGET_CHECK_EN
- Defined: adds ports hash_in (in, 256, transform tx_hash), target_h7 (in, 32), golden (out, 1), golden_nonce (out, 32).
  - golden pulses with hash_valid when hash_in[255:224] < target_h7 (unsigned).
  - golden_nonce <= hash_nonce value of that pulse and holds until the next golden.
  - Reset: golden=0, golden_nonce=0.
- Undefined: those ports and the comparator are absent; all other behaviour is identical.

Test Plan:
- Reset release, idle 10 cycles -> cnt cycles 0,1,2,3,0..; feedback low only at cnt==0; busy=0; no hash_valid.
- LOOP=4, nonce_start=0x10, nonce_end=0x13, start -> 4 issues on consecutive cnt==0 slots; rx_input[127:96] = 0x10..0x13; hash_valid 65 cycles after each issue with hash_nonce 0x10..0x13; done one cycle after the last pulse drains.
- nonce_start=0xFFFFFFFE, nonce_end=0x00000001 -> issued nonces FFFFFFFE, FFFFFFFF, 0, 1; four tagged hashes in that order.
- stop asserted on the same cycle as the 3rd issue slot of a 0..0xFF scan -> exactly 2 hash_valid pulses (nonces 0, 1), then done; start during DRAIN ignored.
- rst_n low mid-scan with 5 jobs in flight, then released -> no hash_valid afterwards; state IDLE; all outputs at reset values.
- TARGET_CHECK_EN defined, target_h7=0x00000100, hash_in[255:224]=0x000000FF on the pulse for nonce 0x42 -> golden=1 for one cycle, golden_nonce=0x42; 0x00000100 on the next pulse -> golden stays 0.
